// File: rtl/dbg_loader_pkg.sv
// Shared definitions for the debug memory loader: command opcodes, FSM states, word size.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package dbg_loader_pkg;

    localparam int WORD_BYTES = 4;

    // Host command opcodes; any other value is treated as a no-op.
    localparam logic [2:0] OP_IWR  = 3'd0;
    localparam logic [2:0] OP_IRD  = 3'd1;
    localparam logic [2:0] OP_DWR  = 3'd2;
    localparam logic [2:0] OP_DRD  = 3'd3;
    localparam logic [2:0] OP_RUN  = 3'd4;
    localparam logic [2:0] OP_HALT = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RD_RSP,
        ST_DONE
    } state_e;

    // Opcodes that target the instruction cache port rather than the data port.
    function automatic logic is_inst_op(input logic [2:0] op);
        return (op == OP_IWR) || (op == OP_IRD);
    endfunction

endpackage

// File: rtl/dbg_port_drv.sv
// One debug cache port: registered address / write data / byte-enable with a single-cycle WE pulse.
// Latency: outputs update one cycle after wr_en/ld_en; we2 is high for exactly that one cycle.
// Backpressure: none; the caller only strobes when a beat is really taken.
//
// Ports: clk/rst (sync, active-high); wr_en loads a2/wd2/we2 from addr/wdata/be;
//        ld_en loads a2 only (read address); a2/wd2/we2 drive the cache debug inputs.
module dbg_port_drv (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        ld_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] a2,
    output logic [31:0] wd2,
    output logic [3:0]  we2
);

    logic [31:0] a2_q, a2_d;
    logic [31:0] wd2_q, wd2_d;
    logic [3:0]  we2_q, we2_d;

    always_comb begin
        a2_d  = a2_q;
        wd2_d = wd2_q;
        // Byte enables self-clear so every write is a one-cycle pulse.
        we2_d = '0;
        if (wr_en) begin
            a2_d  = addr;
            wd2_d = wdata;
            we2_d = be;
        end else if (ld_en) begin
            a2_d = addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a2_q  <= '0;
            wd2_q <= '0;
            we2_q <= '0;
        end else begin
            a2_q  <= a2_d;
            wd2_q <= wd2_d;
            we2_q <= we2_d;
        end
    end

    assign a2  = a2_q;
    assign wd2 = wd2_q;
    assign we2 = we2_q;

endmodule

// File: rtl/dbg_mem_loader.sv
// Host-side master for the core's debug I/D-cache ports: burst word writes/reads plus core hold control.
// Latency: accept -> first WE pulse one cycle after the first wd beat; read word appears RD_LAT+2 cycles after issue.
// Backpressure: cmd_ready only in IDLE; wd_valid low stalls writes; rsp_ready low holds the read word.
//
// Ports: CPU_CLK/CPU_RST (sync, active-high); cmd_* command stream; wd_* write beats;
//        rsp_* read words; op_done completion pulse; core_hold drives the core reset;
//        inst_*/data_* connect to CPU_Debug_InstCache_* / CPU_Debug_DataCache_*.
module dbg_mem_loader
    import dbg_loader_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int LEN_W  = 8
) (
    input  logic             CPU_CLK,
    input  logic             CPU_RST,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             wd_valid,
    output logic             wd_ready,
    input  logic [31:0]      wd_data,
    input  logic [3:0]       wd_be,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             op_done,
    output logic             core_hold,
    output logic [31:0]      inst_a2,
    output logic [31:0]      inst_wd2,
    output logic [3:0]       inst_we2,
    input  logic [31:0]      inst_rd2,
    output logic [31:0]      data_a2,
    output logic [31:0]      data_wd2,
    output logic [3:0]       data_we2,
    input  logic [31:0]      data_rd2
);

    localparam int          LAT_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [31:0] ADDR_STEP = 32'(WORD_BYTES);
    localparam logic [31:0] ADDR_MASK = ~(ADDR_STEP - 32'd1);

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [31:0]      addr_q, addr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic             op_done_q, op_done_d;
    logic             core_hold_q, core_hold_d;

    logic             port_wr;
    logic             port_ld;
    logic [31:0]      port_addr;
    logic             inst_sel;
    logic             cmd_fire;
    logic             wd_fire;
    logic             rsp_fire;

    // Ready signals are pure state decodes, so they carry no input-to-output path.
    assign cmd_ready = (state_q == ST_IDLE);
    assign wd_ready  = (state_q == ST_WR);

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign wd_fire   = wd_valid && wd_ready;
    assign rsp_fire  = rsp_valid_q && rsp_ready;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        lat_d       = lat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        op_done_d   = 1'b0;
        core_hold_d = core_hold_q;
        port_wr     = 1'b0;
        port_ld     = 1'b0;
        port_addr   = addr_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    op_d   = cmd_op;
                    addr_d = cmd_addr & ADDR_MASK;
                    cnt_d  = cmd_len;
                    case (cmd_op)
                        OP_IWR, OP_DWR: state_d = ST_WR;
                        OP_IRD, OP_DRD: begin
                            // Present the read address during the RD_ISSUE cycle itself.
                            state_d   = ST_RD_ISSUE;
                            port_ld   = 1'b1;
                            port_addr = addr_d;
                        end
                        OP_RUN: begin
                            core_hold_d = 1'b0;
                            state_d     = ST_DONE;
                            op_done_d   = 1'b1;
                        end
                        OP_HALT: begin
                            core_hold_d = 1'b1;
                            state_d     = ST_DONE;
                            op_done_d   = 1'b1;
                        end
                        default: begin
                            state_d   = ST_DONE;
                            op_done_d = 1'b1;
                        end
                    endcase
                end
            end

            ST_WR: begin
                if (wd_fire) begin
                    port_wr = 1'b1;
                    addr_d  = addr_q + ADDR_STEP;
                    if (cnt_q == '0) begin
                        // Last beat: its WE pulse lands in the DONE cycle alongside op_done.
                        state_d   = ST_DONE;
                        op_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end

            ST_RD_ISSUE: begin
                state_d = ST_RD_WAIT;
                lat_d   = LAT_W'(RD_LAT - 1);
            end

            ST_RD_WAIT: begin
                if (lat_q == '0) begin
                    rsp_data_d  = is_inst_op(op_q) ? inst_rd2 : data_rd2;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RD_RSP;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end

            ST_RD_RSP: begin
                if (rsp_fire) begin
                    rsp_valid_d = 1'b0;
                    if (cnt_q == '0) begin
                        state_d   = ST_DONE;
                        op_done_d = 1'b1;
                    end else begin
                        addr_d    = addr_q + ADDR_STEP;
                        cnt_d     = cnt_q - 1'b1;
                        state_d   = ST_RD_ISSUE;
                        port_ld   = 1'b1;
                        port_addr = addr_d;
                    end
                end
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    // Port selection follows the op being latched this cycle so reads can load a2 at accept.
    assign inst_sel = is_inst_op(op_d);

    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
            lat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            op_done_q   <= 1'b0;
            core_hold_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            lat_q       <= lat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            op_done_q   <= op_done_d;
            core_hold_q <= core_hold_d;
        end
    end

    dbg_port_drv u_inst_port (
        .clk   (CPU_CLK),
        .rst   (CPU_RST),
        .wr_en (port_wr && inst_sel),
        .ld_en (port_ld && inst_sel),
        .addr  (port_addr),
        .wdata (wd_data),
        .be    (wd_be),
        .a2    (inst_a2),
        .wd2   (inst_wd2),
        .we2   (inst_we2)
    );

    dbg_port_drv u_data_port (
        .clk   (CPU_CLK),
        .rst   (CPU_RST),
        .wr_en (port_wr && !inst_sel),
        .ld_en (port_ld && !inst_sel),
        .addr  (port_addr),
        .wdata (wd_data),
        .be    (wd_be),
        .a2    (data_a2),
        .wd2   (data_wd2),
        .we2   (data_we2)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign op_done   = op_done_q;
    assign core_hold = core_hold_q;

endmodule
